// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
//   Shared definitions for the MEM/WB boundary of the 16-bit pipeline:
//   default widths, the memory-wait timeout and the control FSM state type.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int REG_SEL_W_DEF   = 3;
  localparam int MEM_TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_HALTED   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl
//   Control FSM for the MEM/WB stage: decides when the writeback registers
//   capture, holds the pipeline while a data-memory access is outstanding
//   and detects a memory access that never completes.
//
//   state    | meaning
//   IDLE     | accepting instructions from the MEM stage
//   WAIT_MEM | data-memory access outstanding, pipeline frozen
//   HALTED   | HALT retired, all inputs ignored until reset
//
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   valid_in   MEM stage holds a real instruction
//   mem_acc    instruction performs a data-memory access
//   mem_done   data memory Done
//   halt_in    instruction is HALT
//   stall      combinational freeze of the upstream stages
//   capture    writeback registers load on this edge
//   timeout    access abandoned on this edge, error must be raised
module mem_wb_ctrl
  import mem_wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic mem_acc,
  input  logic mem_done,
  input  logic halt_in,
  output logic stall,
  output logic capture,
  output logic timeout
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (mem_acc && !mem_done) begin
            // The entry cycle already counts as one cycle of waiting.
            stall   = 1'b1;
            state_d = ST_WAIT_MEM;
            cnt_d   = CNT_W'(1);
          end else begin
            capture = 1'b1;
            if (halt_in) state_d = ST_HALTED;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Done takes priority over the timeout threshold.
        if (mem_done) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = halt_in ? ST_HALTED : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline boundary. Selects the writeback value, registers it with
//   the destination register and write enable, and freezes the front of the
//   pipeline while a multi-cycle data-memory access is outstanding.
//   Sticky halt and memory-error flags are kept here.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   valid_in                    MEM stage holds a real instruction
//   aluOutput, readData         ALU result / memory read data
//   memRead, memWrite           load / store
//   memDone, memErr             data memory Done / err
//   memToReg, regWriteEn        writeback select / register write enable
//   writeRegSel, halt_in        destination register / HALT
//   stall_out                   freeze IF/ID/EX/MEM
//   wb_valid, wb_data,
//   wb_regSel, wb_regWrite      registered writeback entry
//   halt_out, err_out           sticky halt / sticky memory error
//
// Optional build macro MEM_WB_STALL_STATS_EN adds saturating 16-bit counters
//   stall_cycles (cycles with stall_out high) and mem_ops (completed accesses).
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_SEL_W   = REG_SEL_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_W-1:0]    aluOutput,
  input  logic [DATA_W-1:0]    readData,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 memDone,
  input  logic                 memErr,
  input  logic                 memToReg,
  input  logic                 regWriteEn,
  input  logic [REG_SEL_W-1:0] writeRegSel,
  input  logic                 halt_in,
  output logic                 stall_out,
  output logic                 wb_valid,
  output logic [DATA_W-1:0]    wb_data,
  output logic [REG_SEL_W-1:0] wb_regSel,
  output logic                 wb_regWrite,
  output logic                 halt_out,
  output logic                 err_out
`ifdef MEM_WB_STALL_STATS_EN
  ,
  output logic [15:0]          stall_cycles,
  output logic [15:0]          mem_ops
`endif
);

  logic mem_acc, capture, timeout, ctrl_stall;

  logic                 wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [REG_SEL_W-1:0] wb_sel_q, wb_sel_d;
  logic                 regwe_q, regwe_d;
  logic                 halt_q, halt_d;
  logic                 err_q, err_d;

  assign mem_acc = valid_in & (memRead | memWrite);

  mem_wb_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .mem_acc  (mem_acc),
    .mem_done (memDone),
    .halt_in  (halt_in),
    .stall    (ctrl_stall),
    .capture  (capture),
    .timeout  (timeout)
  );

  always_comb begin
    wb_valid_d = capture;
    wb_data_d  = wb_data_q;
    wb_sel_d   = wb_sel_q;
    regwe_d    = regwe_q;
    halt_d     = halt_q;
    if (capture) begin
      wb_data_d = memToReg ? readData : aluOutput;
      wb_sel_d  = writeRegSel;
      regwe_d   = regWriteEn;
      halt_d    = halt_q | halt_in;
    end
    // Once halted the inputs are ignored, including a stray memErr.
    err_d = err_q | timeout | (memErr & mem_acc & ~halt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_sel_q   <= '0;
      regwe_q    <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_sel_q   <= wb_sel_d;
      regwe_q    <= regwe_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  // While reset is held the outstanding access is abandoned, so the
  // upstream stages must not stay frozen.
  assign stall_out   = ctrl_stall & rst;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_regSel   = wb_sel_q;
  assign wb_regWrite = wb_valid_q & regwe_q;
  assign halt_out    = halt_q;
  assign err_out     = err_q;

`ifdef MEM_WB_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] ops_cnt_q, ops_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    ops_cnt_d   = ops_cnt_q;
    if (stall_out && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (capture && mem_acc && ops_cnt_q != 16'hFFFF) ops_cnt_d = ops_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      ops_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign mem_ops      = ops_cnt_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Downstream neighbour of the data-memory stage in the 5-stage 16-bit pipeline.
- Consumes the memory stage's ALU result, the multi-cycle data-memory read/write handshake (Stall/Done/err) and the writeback control signals.
- Holds the pipeline while a memory access is outstanding.
- Registers the final writeback value, destination register and write enable into the MEM/WB boundary.

Parameters:
- DATA_W, 16, datapath width.
- REG_SEL_W, 3, register-file select width.
- MEM_TIMEOUT, 32, maximum cycles spent in WAIT_MEM before an error is flagged; must be at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge, with state cleared while rst==0.
- valid_in  in  1  MEM stage holds a real instruction.
- aluOutput  in  DATA_W  ALU result / memory address.
- readData  in  DATA_W  data memory DataOut.
- memRead  in  1  instruction is a load.
- memWrite  in  1  instruction is a store.
- memDone  in  1  data memory Done.
- memErr  in  1  data memory err (unaligned).
- memToReg  in  1  1 selects readData for writeback, 0 selects aluOutput.
- regWriteEn  in  1  instruction writes the register file.
- writeRegSel  in  REG_SEL_W  destination register.
- halt_in  in  1  instruction is HALT.
- stall_out  out  1  freeze IF/ID/EX/MEM.
- wb_valid  out  1  registered writeback entry valid.
- wb_data  out  DATA_W  writeback value.
- wb_regSel  out  REG_SEL_W  destination register.
- wb_regWrite  out  1  register-file write enable; equals wb_valid & captured regWriteEn.
- halt_out  out  1  sticky halt.
- err_out  out  1  sticky memory error.

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE; the timeout counter goes to 0.
  - wb_valid, wb_data, wb_regSel, wb_regWrite, halt_out and err_out all go to 0.
  - This applies from any state, including mid-WAIT_MEM; the outstanding access is abandoned.
- States: IDLE, WAIT_MEM, HALTED.
- Memory access: mem_acc = valid_in & (memRead | memWrite).
- IDLE, valid_in==0: next-edge wb_valid=0; other wb_* regs hold.
- IDLE, valid_in==1 and (!mem_acc or memDone): capture at the next edge, 1-cycle latency.
  - wb_data = memToReg ? readData : aluOutput.
  - wb_regSel = writeRegSel.
  - wb_valid = 1.
- IDLE, mem_acc and !memDone:
  - stall_out=1 combinationally in the same cycle.
  - Next state WAIT_MEM; next wb_valid=0 (bubble).
- WAIT_MEM:
  - stall_out = !memDone (combinational), and upstream holds all inputs stable.
  - Timeout counter increments each cycle.
  - On memDone: capture as above, return to IDLE, clear the counter.
  - wb_valid stays 0 on every cycle until the capture edge.
- Timeout: the counter reaching MEM_TIMEOUT-1 without memDone sets err_out=1, forces IDLE, leaves wb_valid=0 and deasserts stall_out in that cycle.
- memErr==1 while mem_acc: err_out sets at the next edge and is sticky until reset; the capture still proceeds normally.
- Halt: halt_in & valid_in captured (after any memory wait completes) gives halt_out=1 and state HALTED.
  - HALTED ignores all inputs and sets wb_valid=0 and stall_out=0 until reset.
- Simultaneous events:
  - memDone in the same cycle as entry from IDLE means no stall and no WAIT_MEM.
  - memDone together with the timeout threshold: memDone wins and no error is raised.
- Store with regWriteEn==0 gives wb_valid=1 and wb_regWrite=0.

Optional Feature:
- Macro MEM_WB_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles (16 bits), counting cycles with stall_out==1 and saturating at 16'hFFFF.
  - Adds output mem_ops (16 bits), counting completed memory accesses and saturating at 16'hFFFF.
  - Both outputs are cleared by reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - the state encoding type (IDLE=2'b00, WAIT_MEM=2'b01, HALTED=2'b10);
  - the DATA_W and REG_SEL_W defaults;
  - the MEM_TIMEOUT default.
- One natural sub-module, mem_wb_ctrl: FSM, timeout counter and stall_out.
- The parent keeps the capture registers and the writeback mux.

Test Plan:
- ALU op: valid_in=1, memToReg=0, aluOutput=16'h1234, regWriteEn=1, writeRegSel=3'd5 -> next cycle wb_valid=1, wb_data=16'h1234, wb_regSel=5, wb_regWrite=1, stall_out never 1.
- Load, 3-cycle wait: memRead=1, memDone low 3 cycles then high with readData=16'hBEEF -> stall_out=1 for exactly 3 cycles, then wb_data=16'hBEEF, wb_valid=1 one edge after memDone.
- Store, Done same cycle: memWrite=1, memDone=1, regWriteEn=0 -> no stall, wb_valid=1, wb_regWrite=0.
- Timeout: memRead=1, memDone held 0 -> stall_out=1 for 31 cycles, err_out=1 after edge 32, wb_valid=0, state IDLE.
- Reset mid-wait: rst=0 on 2nd WAIT_MEM cycle -> next edge all outputs 0 and stall_out=0; rst=1 then an ALU op captures normally.
- Halt: halt_in=1 with valid_in=1 -> halt_out=1, subsequent valid ALU ops give wb_valid=0; memErr=1 on an earlier load leaves err_out=1 until reset.
